// File: rtl/counter_unit.sv
// One 8254 counting channel: control word, count write, counter/status latch and read-back,
// with a 16-bit binary/BCD down-counter driven by the synchronised CntClk pin (modes 0, 2, 3).
module counter_unit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       CwValid,
  input  logic [5:0] Cw,
  input  logic       CountLatchCmd,
  input  logic       StatusLatchCmd,
  input  logic       WriteStrobe,
  input  logic       ReadStrobe,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  input  logic       CntClk,
  input  logic       Gate,
  output logic       Out
);

  // Pin synchronisers
  logic [SYNC_STAGES-1:0] cclk_sync_q, gate_sync_q;
  logic                   cclk_prev_q, gate_prev_q;
  logic                   cclk_s, gate_s, tick, gate_rise;

  // Channel state
  logic [5:0]  cw_q, cw_d;
  logic [15:0] cr_q, cr_d;
  logic [15:0] ce_q, ce_d;
  logic [15:0] ol_q, ol_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        out_q, out_d;
  logic        null_q, null_d;
  logic        wr_msb_q, wr_msb_d;
  logic        rd_msb_q, rd_msb_d;
  logic        ol_valid_q, ol_valid_d;
  logic        status_valid_q, status_valid_d;
  logic        load_pending_q, load_pending_d;
  logic        reload_pending_q, reload_pending_d;
  logic        running_q, running_d;
  logic        odd_q, odd_d;

  // Decoded control word
  logic [1:0]  rw;
  logic [2:0]  mode;
  logic        bcd;
  logic        is_m0, is_m2, is_m3, mode_ok;
  logic        cw_accept;
  logic        count_done;
  logic [15:0] ce_dec1, ce_dec2, m3_reload, rd_src;

  // One-step down-count; BCD borrows digit by digit and wraps 0000 -> 9999
  function automatic logic [15:0] dec1(input logic [15:0] v, input logic is_bcd);
    logic [15:0] r;
    logic        borrow;
    if (!is_bcd) return v - 16'd1;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign cclk_s    = cclk_sync_q[SYNC_STAGES-1];
  assign gate_s    = gate_sync_q[SYNC_STAGES-1];
  assign tick      = cclk_prev_q & ~cclk_s;
  assign gate_rise = ~gate_prev_q & gate_s;

  assign rw        = cw_q[5:4];
  assign mode      = cw_q[3:1];
  assign bcd       = cw_q[0];
  assign is_m0     = (mode == 3'b000);
  assign is_m2     = (mode[1:0] == 2'b10);
  assign is_m3     = (mode[1:0] == 2'b11);
  assign mode_ok   = is_m0 | is_m2 | is_m3;
  // RW=00 is a latch request routed through CountLatchCmd, not a mode change
  assign cw_accept = CwValid & (Cw[5:4] != 2'b00);

  assign ce_dec1   = dec1(ce_q, bcd);
  assign ce_dec2   = dec1(ce_dec1, bcd);
  // Mode 3 always counts an even value; an odd count drops its LSB (same bit in BCD)
  assign m3_reload = {cr_q[15:1], 1'b0};
  assign rd_src    = ol_valid_q ? ol_q : ce_q;

  // Next-state: tick, gate, count write, read, control write, then latch commands
  always_comb begin
    cw_d             = cw_q;
    cr_d             = cr_q;
    ce_d             = ce_q;
    ol_d             = ol_q;
    status_d         = status_q;
    data_out_d       = data_out_q;
    out_d            = out_q;
    null_d           = null_q;
    wr_msb_d         = wr_msb_q;
    rd_msb_d         = rd_msb_q;
    ol_valid_d       = ol_valid_q;
    status_valid_d   = status_valid_q;
    load_pending_d   = load_pending_q;
    reload_pending_d = reload_pending_q;
    running_d        = running_q;
    odd_d            = odd_q;
    count_done       = 1'b0;

    if (tick && mode_ok) begin
      if (load_pending_q || (reload_pending_q && !is_m0)) begin
        ce_d             = is_m3 ? m3_reload : cr_q;
        odd_d            = cr_q[0];
        null_d           = 1'b0;
        running_d        = 1'b1;
        load_pending_d   = 1'b0;
        reload_pending_d = 1'b0;
        if (!is_m0) out_d = 1'b1;
      end else if (running_q && gate_s) begin
        if (is_m0) begin
          ce_d = ce_dec1;
          if (ce_dec1 == 16'd0) out_d = 1'b1;
        end else if (is_m2) begin
          if (ce_q == 16'd2) begin
            ce_d  = 16'd1;
            out_d = 1'b0;
          end else if (ce_q == 16'd1) begin
            ce_d   = cr_q;
            out_d  = 1'b1;
            null_d = 1'b0;
          end else begin
            ce_d = ce_dec1;
          end
        end else begin
          // Odd high phase spends one extra tick parked at zero before toggling
          if (ce_q == 16'd2 && out_q && odd_q) begin
            ce_d = 16'd0;
          end else if (ce_q == 16'd2 || (ce_q == 16'd0 && odd_q)) begin
            out_d  = ~out_q;
            ce_d   = m3_reload;
            odd_d  = cr_q[0];
            null_d = 1'b0;
          end else begin
            ce_d = ce_dec2;
          end
        end
      end
    end

    if (gate_rise && (is_m2 || is_m3) && running_q) reload_pending_d = 1'b1;
    if (!gate_s && (is_m2 || is_m3)) out_d = 1'b1;

    if (WriteStrobe && !cw_accept) begin
      case (rw)
        2'b01: begin
          cr_d       = {8'h00, DataIn};
          count_done = 1'b1;
        end
        2'b10: begin
          cr_d       = {DataIn, 8'h00};
          count_done = 1'b1;
        end
        2'b11: begin
          if (!wr_msb_q) begin
            cr_d[7:0] = DataIn;
            wr_msb_d  = 1'b1;
            if (is_m0) begin
              out_d          = 1'b0;
              running_d      = 1'b0;
              load_pending_d = 1'b0;
            end
          end else begin
            cr_d[15:8] = DataIn;
            wr_msb_d   = 1'b0;
            count_done = 1'b1;
          end
        end
        default: ;
      endcase
      if (count_done) begin
        null_d = 1'b1;
        // Modes 2/3 already counting pick the new value up at their next reload
        if (is_m0 || !running_q) load_pending_d = 1'b1;
      end
    end

    if (ReadStrobe && !cw_accept) begin
      if (status_valid_q) begin
        data_out_d     = status_q;
        status_valid_d = 1'b0;
      end else begin
        case (rw)
          2'b10: begin
            data_out_d = rd_src[15:8];
            ol_valid_d = 1'b0;
          end
          2'b11: begin
            data_out_d = rd_msb_q ? rd_src[15:8] : rd_src[7:0];
            rd_msb_d   = ~rd_msb_q;
            if (rd_msb_q) ol_valid_d = 1'b0;
          end
          default: begin
            data_out_d = rd_src[7:0];
            ol_valid_d = 1'b0;
          end
        endcase
      end
    end

    if (cw_accept) begin
      cw_d             = Cw;
      null_d           = 1'b1;
      wr_msb_d         = 1'b0;
      rd_msb_d         = 1'b0;
      ol_valid_d       = 1'b0;
      status_valid_d   = 1'b0;
      running_d        = 1'b0;
      load_pending_d   = 1'b0;
      reload_pending_d = 1'b0;
      out_d            = (Cw[3:1] != 3'b000);
    end

    if (CountLatchCmd && (cw_accept || !ol_valid_q)) begin
      ol_d       = ce_q;
      ol_valid_d = 1'b1;
    end

    if (StatusLatchCmd && (cw_accept || !status_valid_q)) begin
      status_d       = cw_accept ? {(Cw[3:1] != 3'b000), 1'b1, Cw} : {out_q, null_q, cw_q};
      status_valid_d = 1'b1;
    end
  end

  // Synchroniser and edge-detect flops
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      cclk_sync_q <= '0;
      gate_sync_q <= '0;
      cclk_prev_q <= 1'b0;
      gate_prev_q <= 1'b0;
    end else begin
      cclk_sync_q <= {cclk_sync_q[SYNC_STAGES-2:0], CntClk};
      gate_sync_q <= {gate_sync_q[SYNC_STAGES-2:0], Gate};
      cclk_prev_q <= cclk_s;
      gate_prev_q <= gate_s;
    end
  end

  // Channel state registers
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      cw_q             <= '0;
      cr_q             <= '0;
      ce_q             <= '0;
      ol_q             <= '0;
      status_q         <= '0;
      data_out_q       <= '0;
      out_q            <= 1'b0;
      null_q           <= 1'b1;
      wr_msb_q         <= 1'b0;
      rd_msb_q         <= 1'b0;
      ol_valid_q       <= 1'b0;
      status_valid_q   <= 1'b0;
      load_pending_q   <= 1'b0;
      reload_pending_q <= 1'b0;
      running_q        <= 1'b0;
      odd_q            <= 1'b0;
    end else begin
      cw_q             <= cw_d;
      cr_q             <= cr_d;
      ce_q             <= ce_d;
      ol_q             <= ol_d;
      status_q         <= status_d;
      data_out_q       <= data_out_d;
      out_q            <= out_d;
      null_q           <= null_d;
      wr_msb_q         <= wr_msb_d;
      rd_msb_q         <= rd_msb_d;
      ol_valid_q       <= ol_valid_d;
      status_valid_q   <= status_valid_d;
      load_pending_q   <= load_pending_d;
      reload_pending_q <= reload_pending_d;
      running_q        <= running_d;
      odd_q            <= odd_d;
    end
  end

  assign DataOut = data_out_q;
  assign Out     = out_q;

endmodule

// File: tb/tb_counter_unit.sv
// Self-checking bench for counter_unit: directed steps plus randomized counts checked
// against an arithmetic model of each mode's waveform and count sequence.
module tb_counter_unit;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic       CwValid = 1'b0;
  logic [5:0] Cw = '0;
  logic       CountLatchCmd = 1'b0;
  logic       StatusLatchCmd = 1'b0;
  logic       WriteStrobe = 1'b0;
  logic       ReadStrobe = 1'b0;
  logic [7:0] DataIn = '0;
  logic [7:0] DataOut;
  logic       CntClk = 1'b0;
  logic       Gate = 1'b0;
  logic       Out;

  int n_cmp = 0;
  int n_err = 0;

  counter_unit #(.SYNC_STAGES(2)) dut (
    .Clock          (Clock),
    .ResetN         (ResetN),
    .CwValid        (CwValid),
    .Cw             (Cw),
    .CountLatchCmd  (CountLatchCmd),
    .StatusLatchCmd (StatusLatchCmd),
    .WriteStrobe    (WriteStrobe),
    .ReadStrobe     (ReadStrobe),
    .DataIn         (DataIn),
    .DataOut        (DataOut),
    .CntClk         (CntClk),
    .Gate           (Gate),
    .Out            (Out)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All drive tasks start and end on a falling Clock edge
  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic ctrl(input logic [5:0] cw);
    Cw = cw; CwValid = 1'b1; cyc(1); CwValid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b);
    DataIn = b; WriteStrobe = 1'b1; cyc(1); WriteStrobe = 1'b0;
  endtask

  task automatic rd(output logic [7:0] b);
    ReadStrobe = 1'b1; cyc(1); ReadStrobe = 1'b0; b = DataOut;
  endtask

  task automatic rd16(output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(lo); rd(hi); v = {hi, lo};
  endtask

  task automatic tick();
    CntClk = 1'b1; cyc(4); CntClk = 1'b0; cyc(4);
  endtask

  // Count-latch pulse lands on the very cycle the synchronised falling edge is seen
  task automatic tick_latch();
    CntClk = 1'b1; cyc(4); CntClk = 1'b0; cyc(2);
    CountLatchCmd = 1'b1; cyc(1); CountLatchCmd = 1'b0; cyc(1);
  endtask

  task automatic set_gate(input logic g);
    Gate = g; cyc(5);
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  // Effective initial count: zero stands for the full range
  function automatic int eff(input logic [15:0] cr, input bit is_bcd);
    if (is_bcd) return (cr == 16'h0) ? 10000 : bcd2int(cr);
    return (cr == 16'h0) ? 65536 : int'(cr);
  endfunction

  function automatic logic [15:0] m0_val(input logic [15:0] cr, input bit is_bcd, input int k);
    int m, v;
    m = is_bcd ? 10000 : 65536;
    v = ((eff(cr, is_bcd) - k) % m + m) % m;
    return is_bcd ? int2bcd(v) : 16'(v);
  endfunction

  // Mode 0, RW=11: Out low until k decrements reach the count, count = N - k modulo range
  task automatic run_m0(input logic [15:0] cr, input bit is_bcd, input int nt);
    logic [15:0] v;
    int          n;
    n = eff(cr, is_bcd);
    ctrl({2'b11, 3'b000, is_bcd});
    chk("m0_out_after_cw", 16'(Out), 16'h0);
    wr(cr[7:0]); wr(cr[15:8]);
    tick();
    rd16(v);
    chk("m0_loaded", v, cr);
    chk("m0_out_loaded", 16'(Out), 16'h0);
    for (int k = 1; k <= nt; k++) begin
      tick();
      chk("m0_out", 16'(Out), 16'(k >= n));
      rd16(v);
      chk("m0_ce", v, m0_val(cr, is_bcd, k));
    end
  endtask

  // Mode 2, RW=01: position p in period N; Out low only at p=N-1, count = N - p
  task automatic m2_check(input int n, input int t);
    logic [7:0] b;
    int         p;
    p = t % n;
    chk("m2_out", 16'(Out), 16'(p != n - 1));
    rd(b);
    chk("m2_ce", 16'(b), 16'(n - p));
  endtask

  task automatic run_m2(input int n, input int nt);
    ctrl(6'h14);
    chk("m2_out_after_cw", 16'(Out), 16'h1);
    wr(8'(n));
    tick();
    m2_check(n, 0);
    for (int t = 1; t <= nt; t++) begin
      tick();
      m2_check(n, t);
    end
  endtask

  // Mode 3: high for ceil(N/2) ticks then low for floor(N/2), starting at the load tick
  task automatic run_m3(input int n, input int nt);
    ctrl(6'h16);
    chk("m3_out_after_cw", 16'(Out), 16'h1);
    wr(8'(n));
    tick();
    for (int t = 0; t <= nt; t++) begin
      if (t > 0) tick();
      chk("m3_out", 16'(Out), 16'((t % n) < (n + 1) / 2));
    end
  endtask

  logic [7:0]  b;
  logic [15:0] v;
  int          rn;

  initial begin
    // Power-on reset
    cyc(3);
    chk("rst_dataout", 16'(DataOut), 16'h0);
    chk("rst_out", 16'(Out), 16'h0);
    ResetN = 1'b1;
    cyc(1);
    set_gate(1'b1);

    // Reset in the middle of a count
    ctrl(6'h30); wr(8'h50); wr(8'h00); tick(); tick();
    ResetN = 1'b0; cyc(2); ResetN = 1'b1; cyc(1);
    chk("midrst_dataout", 16'(DataOut), 16'h0);
    chk("midrst_out", 16'(Out), 16'h0);
    rd(b);
    chk("midrst_live", 16'(b), 16'h0);
    tick();
    rd(b);
    chk("midrst_halted", 16'(b), 16'h0);
    chk("midrst_out_halted", 16'(Out), 16'h0);
    set_gate(1'b1);

    // Mode 0 binary, directed and random counts
    run_m0(16'h0005, 1'b0, 8);
    rn = int'($urandom_range(1, 15));
    run_m0(16'(rn), 1'b0, rn + 2);

    // Mode 0 BCD: 0100 -> 0099, 0000 wraps to 9999, plus a random BCD count
    run_m0(16'h0100, 1'b1, 2);
    run_m0(16'h0000, 1'b1, 2);
    rn = int'($urandom_range(1, 40));
    run_m0(int2bcd(rn), 1'b1, rn + 2);

    // Mode 2 count 4, then gate low while Out is low, then restart on gate rise
    run_m2(4, 10);
    tick();
    m2_check(4, 11);
    set_gate(1'b0);
    chk("m2_gate_low_out", 16'(Out), 16'h1);
    tick();
    rd(b);
    chk("m2_gate_low_halt", 16'(b), 16'h1);
    chk("m2_gate_low_out2", 16'(Out), 16'h1);
    set_gate(1'b1);
    tick();
    m2_check(4, 0);
    for (int t = 1; t <= 5; t++) begin
      tick();
      m2_check(4, t);
    end
    run_m2(int'($urandom_range(2, 9)), 12);

    // Mode 3 square wave
    run_m3(5, 10);
    run_m3(4, 8);
    rn = int'($urandom_range(2, 12));
    run_m3(rn, 2 * rn);

    // Unsupported mode holds Out high with no counting
    ctrl(6'h12);
    chk("m1_out", 16'(Out), 16'h1);
    wr(8'h02); tick(); tick(); tick();
    chk("m1_out_after_ticks", 16'(Out), 16'h1);

    // Control word and count byte in the same cycle: the byte is dropped
    Cw = 6'h14; CwValid = 1'b1; DataIn = 8'h07; WriteStrobe = 1'b1;
    cyc(1);
    CwValid = 1'b0; WriteStrobe = 1'b0;
    wr(8'h03); tick();
    rd(b);
    chk("cw_wr_same_cycle", 16'(b), 16'h3);

    // Count latch holds through ticks; a second latch while unread is ignored
    ctrl(6'h30); wr(8'h34); wr(8'h12); tick();
    CountLatchCmd = 1'b1; cyc(1); CountLatchCmd = 1'b0;
    tick(); tick(); tick();
    CountLatchCmd = 1'b1; cyc(1); CountLatchCmd = 1'b0;
    rd(b); chk("ol_lsb", 16'(b), 16'h34);
    rd(b); chk("ol_msb", 16'(b), 16'h12);
    rd16(v); chk("live_after_ol", v, 16'h1231);

    // Status before load shows NullCount set
    ctrl(6'h30);
    StatusLatchCmd = 1'b1; cyc(1); StatusLatchCmd = 1'b0;
    rd(b); chk("status_null", 16'(b), 16'h70);

    // Status plus count latch: status byte first, then latched count
    ctrl(6'h30); wr(8'h34); wr(8'h12); tick();
    StatusLatchCmd = 1'b1; CountLatchCmd = 1'b1; cyc(1);
    StatusLatchCmd = 1'b0; CountLatchCmd = 1'b0;
    tick();
    rd(b); chk("status_byte", 16'(b), 16'h30);
    rd(b); chk("st_ol_lsb", 16'(b), 16'h34);
    rd(b); chk("st_ol_msb", 16'(b), 16'h12);

    // Latch on the tick cycle captures the pre-decrement value
    ctrl(6'h30); wr(8'h10); wr(8'h00); tick();
    tick_latch();
    rd16(v); chk("latch_on_tick", v, 16'h0010);
    rd16(v); chk("live_after_tick", v, 16'h000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
